// File: rtl/dcache_direct_mapped.sv
// ============================================================================
// dcache_direct_mapped : 8-line x 4-byte direct-mapped write-back cache.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dcache_direct_mapped (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FETCH      = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q  [8];
  logic [31:0] data_d  [8];
  logic [2:0]  tag_q   [8];
  logic [2:0]  tag_d   [8];
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [5:0]  mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic [31:0] fill_q, fill_d;

  logic [2:0]  addr_tag;
  logic [2:0]  index;
  logic [4:0]  bit_ofs;
  logic        access;
  logic        hit;

  assign addr_tag = address[7:5];
  assign index    = address[4:2];
  assign bit_ofs  = {address[1:0], 3'b000};
  assign access   = read ^ write;
  assign hit      = valid_q[index] && (tag_q[index] == addr_tag);

  assign readdata      = hit ? data_q[index][bit_ofs +: 8] : 8'h00;
  assign busywait      = access && !(state_q == IDLE && hit);
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

  always_comb begin
    state_d         = state_q;
    data_d          = data_q;
    tag_d           = tag_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    fill_d          = fill_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            if (write) begin
              data_d[index][bit_ofs +: 8] = writedata;
              dirty_d[index]              = 1'b1;
            end
          end else if (valid_q[index] && dirty_q[index]) begin
            state_d         = WRITE_BACK;
            mem_write_d     = 1'b1;
            mem_address_d   = {tag_q[index], index};
            mem_writedata_d = data_q[index];
          end else begin
            state_d       = FETCH;
            mem_read_d    = 1'b1;
            mem_address_d = {addr_tag, index};
          end
        end
      end
      WRITE_BACK: begin
        if (!mem_busywait) begin
          state_d       = FETCH;
          mem_write_d   = 1'b0;
          mem_read_d    = 1'b1;
          mem_address_d = {addr_tag, index};
        end
      end
      FETCH: begin
        if (!mem_busywait) begin
          state_d    = UPDATE;
          mem_read_d = 1'b0;
          fill_d     = mem_readdata;
        end
      end
      UPDATE: begin
        // Request is held stable through the miss, so index/tag still name the target line.
        state_d        = IDLE;
        data_d[index]  = fill_q;
        tag_d[index]   = addr_tag;
        valid_d[index] = 1'b1;
        dirty_d[index] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= 8'h00;
      dirty_q         <= 8'h00;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= 6'd0;
      mem_writedata_q <= 32'd0;
      fill_q          <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= 32'd0;
        tag_q[i]  <= 3'd0;
      end
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      tag_q           <= tag_d;
      valid_q         <= valid_d;
      dirty_q         <= dirty_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      fill_q          <= fill_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;
  logic        post_update_q, post_update_d;

  // The IDLE hit right after UPDATE finishes a miss and is not a fresh hit.
  always_comb begin
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    post_update_d = (state_q == UPDATE);
    if (state_q == IDLE && access) begin
      if (hit) begin
        if (!post_update_q && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      end else if (miss_count_q != 16'hFFFF) begin
        miss_count_d = miss_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q   <= 16'd0;
      miss_count_q  <= 16'd0;
      post_update_q <= 1'b0;
    end else begin
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
      post_update_q <= post_update_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_direct_mapped.sv
// ============================================================================
// tb_dcache_direct_mapped : directed + random checks of the data cache against
// a coherent byte-memory reference and a simple hit/miss latency model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dcache_direct_mapped;

  localparam int M = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  writedata = 8'h00;
  logic [7:0]  readdata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_direct_mapped dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- block memory with an M-cycle request latency ----------
  logic [31:0] mem_blk  [64];
  logic [31:0] mem_init [64];
  logic        load_mem = 1'b0;
  int          cnt;

  assign mem_busywait = (mem_read || mem_write) && (cnt != M - 1);
  assign mem_readdata = mem_blk[mem_address];

  always @(posedge clock or posedge reset) begin
    if (reset) cnt <= 0;
    else if (mem_read || mem_write) cnt <= (cnt == M - 1) ? 0 : cnt + 1;
    else cnt <= 0;
  end

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem_blk[i] <= mem_init[i];
    end else if (mem_write && !mem_busywait) begin
      mem_blk[mem_address] <= mem_writedata;
    end
  end

  // Request log sampled away from the active edge.
  int          n_rd = 0;
  int          n_wr = 0;
  logic [5:0]  last_rd_addr = 6'd0;
  logic [5:0]  last_wr_addr = 6'd0;
  logic [31:0] last_wr_data = 32'd0;

  always @(negedge clock) begin
    if (mem_read) begin
      n_rd++;
      last_rd_addr = mem_address;
    end
    if (mem_write) begin
      n_wr++;
      last_wr_addr = mem_address;
      last_wr_data = mem_writedata;
    end
  end

  // ---------------- reference model ---------------------------------------
  logic [7:0] ref_bytes [256];
  logic [2:0] rt [8];
  logic [7:0] rv;
  logic [7:0] rd_dirty;
  int         ref_hits;
  int         ref_misses;

  int total = 0;
  int bad   = 0;

  int          stalls;
  logic [7:0]  rdv;
  int          rd_base;
  int          wr_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cache contents are lost on reset; memory holds whatever was written back.
  task automatic model_reset();
    rv         = 8'h00;
    rd_dirty   = 8'h00;
    ref_hits   = 0;
    ref_misses = 0;
    for (int i = 0; i < 8; i++) rt[i] = 3'd0;
    for (int b = 0; b < 64; b++)
      for (int o = 0; o < 4; o++) ref_bytes[b * 4 + o] = mem_blk[b][o * 8 +: 8];
  endtask

  task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd);
    @(negedge clock);
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    rd_base   = n_rd;
    wr_base   = n_wr;
    #1;
    stalls = 0;
    while (busywait && stalls < 100) begin
      @(negedge clock);
      #1;
      stalls++;
    end
    rdv = readdata;
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, input string tag);
    logic [2:0] idx;
    logic       h;
    int         exp_stall;
    idx = a[4:2];
    h   = rv[idx] && (rt[idx] == a[7:5]);
    exp_stall = h ? 0 : ((rv[idx] && rd_dirty[idx]) ? 2 * M + 2 : M + 2);
    access(rd, wr, a, wd);
    chk({tag, "_stall"}, stalls, exp_stall);
    if (rd) chk({tag, "_rdata"}, {24'd0, rdv}, {24'd0, ref_bytes[a]});
    if (h) ref_hits++;
    else begin
      ref_misses++;
      rt[idx]       = a[7:5];
      rv[idx]       = 1'b1;
      rd_dirty[idx] = 1'b0;
    end
    if (wr) begin
      ref_bytes[a]  = wd;
      rd_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] blk8;
    int          waitc;

    for (int i = 0; i < 64; i++) mem_init[i] = $urandom;
    mem_init[0] = 32'h4433_2211;
    blk8 = mem_init[8];

    // Reset state
    #12;
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_mem_address", {26'd0, mem_address}, 32'd0);
    chk("rst_mem_wdata", mem_writedata, 32'd0);
    chk("rst_readdata", {24'd0, readdata}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    load_mem = 1'b1;
    @(negedge clock);
    load_mem = 1'b0;
    model_reset();

    // Cold read miss of block 0
    cpu_op(1'b1, 1'b0, 8'h00, 8'h00, "cold_rd00");
    chk("cold_rd00_value", {24'd0, rdv}, 32'h11);
    chk("cold_rd00_fetch_addr", {26'd0, last_rd_addr}, 32'h00);
    chk("cold_rd00_no_wb", n_wr - wr_base, 0);

    // Hit on the same line
    cpu_op(1'b1, 1'b0, 8'h03, 8'h00, "hit_rd03");
    chk("hit_rd03_value", {24'd0, rdv}, 32'h44);
    chk("hit_rd03_no_fetch", n_rd - rd_base, 0);

    // Write hit then read back
    cpu_op(1'b0, 1'b1, 8'h01, 8'hAB, "hit_wr01");
    cpu_op(1'b1, 1'b0, 8'h01, 8'h00, "hit_rd01");
    chk("hit_rd01_value", {24'd0, rdv}, 32'hAB);

    // Conflict miss evicting the dirty line
    cpu_op(1'b1, 1'b0, 8'h20, 8'h00, "dirty_rd20");
    chk("dirty_wb_addr", {26'd0, last_wr_addr}, 32'h00);
    chk("dirty_wb_data", last_wr_data, 32'h4433_AB11);
    chk("dirty_fetch_addr", {26'd0, last_rd_addr}, 32'h08);
    chk("dirty_rd20_value", {24'd0, rdv}, {24'd0, blk8[7:0]});
    chk("dirty_wb_in_mem", mem_blk[0], 32'h4433_AB11);

    // Reset asserted in the middle of a fetch
    @(negedge clock);
    read    = 1'b1;
    address = 8'h40;
    waitc   = 0;
    while (!mem_read && waitc < 20) begin
      @(negedge clock);
      waitc++;
    end
    chk("rstmid_fetch_started", {31'd0, mem_read}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rstmid_readdata", {24'd0, readdata}, 32'd0);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    cpu_op(1'b1, 1'b0, 8'h20, 8'h00, "after_rst_rd20");

    // read and write together is not an access
    @(negedge clock);
    read      = 1'b1;
    write     = 1'b1;
    address   = 8'h05;
    writedata = 8'h5A;
    rd_base   = n_rd;
    wr_base   = n_wr;
    #1;
    chk("both_busywait", {31'd0, busywait}, 32'd0);
    repeat (3) @(negedge clock);
    chk("both_no_mem_req", (n_rd - rd_base) + (n_wr - wr_base), 0);
    read  = 1'b0;
    write = 1'b0;
    cpu_op(1'b1, 1'b0, 8'h20, 8'h00, "both_state_kept");
    cpu_op(1'b1, 1'b0, 8'h05, 8'h00, "both_no_write");

`ifdef DCACHE_STATS_EN
    #1;
    chk("stats_hits", {16'd0, hit_count}, ref_hits);
    chk("stats_misses", {16'd0, miss_count}, ref_misses);
`endif

    // Random traffic against the coherent byte-memory reference
    for (int n = 0; n < 150; n++) begin
      logic [7:0] a;
      logic       is_wr;
      a     = 8'($urandom);
      is_wr = 1'($urandom_range(0, 1));
      cpu_op(!is_wr, is_wr, a, 8'($urandom), is_wr ? "rnd_wr" : "rnd_rd");
    end

`ifdef DCACHE_STATS_EN
    #1;
    chk("stats_hits_rnd", {16'd0, hit_count}, ref_hits);
    chk("stats_misses_rnd", {16'd0, miss_count}, ref_misses);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
